// File: rtl/booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_ctrl
// Brief    : Sequencer for a Booth shift-add multiplier datapath; issues
//            clear/load/shift strobes for N iterations and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_ctrl #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] booth_pair,
    output logic       dp_clr,
    output logic       dp_load_m,
    output logic       dp_load_s,
    output logic       dp_shift,
    output logic       alu_sub,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOADM = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_ADD   = 3'd4;
    localparam logic [2:0] S_SHIFT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_pair;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pair  <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE || r_state == S_CLEAR) begin
                r_cnt <= '0;
            end else if (r_state == S_SHIFT && r_cnt != C_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Captured so the add/subtract choice stays stable through ADD
            if (r_state == S_EVAL) begin
                r_pair <= booth_pair;
            end
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = S_LOADM;
            S_LOADM: w_next = S_EVAL;
            S_EVAL:  w_next = (booth_pair[1] ^ booth_pair[0]) ? S_ADD : S_SHIFT;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = (r_cnt == C_LAST) ? S_DONE : S_EVAL;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dp_clr    = (r_state == S_CLEAR);
        dp_load_m = (r_state == S_LOADM);
        dp_load_s = (r_state == S_ADD);
        dp_shift  = (r_state == S_SHIFT);
        alu_sub   = (r_state == S_ADD) && (r_pair == 2'b10);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_ctrl
// Brief    : Bench for booth_mult_ctrl with a behavioural Booth datapath and
//            a product scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] booth_pair;
    logic       dp_clr, dp_load_m, dp_load_s, dp_shift, alu_sub, busy, done;

    booth_mult_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .booth_pair (booth_pair),
        .dp_clr     (dp_clr),
        .dp_load_m  (dp_load_m),
        .dp_load_s  (dp_load_s),
        .dp_shift   (dp_shift),
        .alu_sub    (alu_sub),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Datapath: accumulator carries one guard bit so -2^(N-1) multiplicands work
    logic signed [N:0]   top    = '0;
    logic        [N-1:0] bot    = '0;
    logic                qm1    = 1'b0;
    logic        [N-1:0] mcand  = '0;
    logic        [N-1:0] mplier = '0;
    logic        [N:0]   mext;

    assign mext       = {mcand[N-1], mcand};
    assign booth_pair = {bot[0], qm1};

    always @(posedge clk) begin
        if (dp_clr) begin
            top <= '0;
            bot <= '0;
            qm1 <= 1'b0;
        end else if (dp_load_s) begin
            top <= alu_sub ? (top - $signed(mext)) : (top + $signed(mext));
        end else if (dp_load_m) begin
            bot <= mplier;
        end else if (dp_shift) begin
            top <= {top[N], top[N:1]};
            bot <= {top[0], bot[N-1:1]};
            qm1 <= bot[0];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_shift  = 0;
    int n_load   = 0;
    int n_done   = 0;
    logic           sub_q[$];
    logic [2*N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dp_shift)  n_shift++;
        if (dp_load_s) begin
            n_load++;
            sub_q.push_back(alu_sub);
        end
        if (done) n_done++;
        n_checks++;
        assert ($countones({dp_clr, dp_load_m, dp_load_s, dp_shift}) <= 1) else begin
            n_fail++;
            $error("FAIL strobe_excl: observed %b expected at most one high",
                   {dp_clr, dp_load_m, dp_load_s, dp_shift});
        end
        n_checks++;
        assert (!(alu_sub && !dp_load_s)) else begin
            n_fail++;
            $error("FAIL alu_sub_outside_add: observed 1 expected 0");
        end
    end

    function automatic logic [6:0] outs();
        return {dp_clr, dp_load_m, dp_load_s, dp_shift, alu_sub, busy, done};
    endfunction

    task automatic wait_done(output int dcyc);
        dcyc = 0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            @(negedge clk);
            if (done) dcyc = c;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [2*N-1:0] e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check(tag, 32'({top[N-1:0], bot}), 32'(e));
    endtask

    // One full multiply with expectations derived from the operand bits
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit pulse_mid);
        int             na, exp_cyc, dcyc, p, b_sh, b_ld, b_dn;
        logic [N-1:0]   exp_sub, obs_sub;
        logic           cur, prev;
        na      = 0;
        exp_sub = '0;
        obs_sub = '0;
        for (int i = 0; i < N; i++) begin
            cur  = b[i];
            prev = (i == 0) ? 1'b0 : b[i-1];
            if (cur != prev) begin
                exp_sub[na] = cur;
                na++;
            end
        end
        exp_cyc = 2 + 2*N + na + 1;
        p = int'($signed(a)) * int'($signed(b));

        @(negedge clk);
        mcand  = a;
        mplier = b;
        exp_q.push_back(p[2*N-1:0]);
        b_sh = n_shift;
        b_ld = n_load;
        b_dn = n_done;
        sub_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        dcyc = 0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) check("clr_cycle1", 32'(dp_clr), 32'd1);
            if (pulse_mid) start = (c == 3 || c == 4);
            if (done) dcyc = c;
        end
        start = 1'b0;
        check("done_cycle", 32'(dcyc), 32'(exp_cyc));
        check("busy_at_done", 32'(busy), 32'd1);
        pop_check("product");

        @(negedge clk);
        check("done_width", 32'({done, busy}), 32'd0);
        for (int i = 0; i < sub_q.size() && i < N; i++) obs_sub[i] = sub_q[i];
        check("shift_count", 32'(n_shift - b_sh), 32'(N));
        check("load_s_count", 32'(n_load - b_ld), 32'(na));
        check("alu_sub_seq", 32'(obs_sub), 32'(exp_sub));
        if (pulse_mid) repeat (20) @(negedge clk);
        check("done_count", 32'(n_done - b_dn), 32'd1);
    endtask

    initial begin
        int dcyc, b_dn;

        // Reset held with start asserted
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        run_op(4'd3, 4'b0000, 1'b0);     // zero multiplier, done cycle 11
        run_op(4'd3, 4'b0101, 1'b0);     // 3*5, four adds, done cycle 15
        run_op(4'b1101, 4'b1110, 1'b0);  // -3 * -2 = 6
        run_op(4'd5, 4'b0110, 1'b1);     // start pulses in EVAL and SHIFT

        // Back-to-back with start held high
        @(negedge clk);
        mcand  = 4'd2;
        mplier = 4'd3;
        exp_q.push_back(8'd6);
        exp_q.push_back(8'd6);
        start = 1'b1;
        wait_done(dcyc);
        check("b2b_first_done", 32'(dcyc != 0), 32'd1);
        pop_check("b2b_first_product");
        @(negedge clk);
        check("b2b_idle", 32'({dp_clr, busy}), 32'd0);
        @(negedge clk);
        check("b2b_clear", 32'(dp_clr), 32'd1);
        start = 1'b0;
        wait_done(dcyc);
        check("b2b_second_done", 32'(dcyc != 0), 32'd1);
        pop_check("b2b_second_product");

        // Reset during ADD aborts the multiply
        @(negedge clk);
        mcand  = 4'd1;
        mplier = 4'b0101;
        b_dn   = n_done;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_add", 32'(dp_load_s), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", 32'(outs()), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - b_dn), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        // Full operand sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), 1'b0);
            end
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
